// File: rtl/matmul_seq_ctrl.sv
// matmul_seq_ctrl: job sequencer for a 3x3 MAC-array matrix multiplier.
// Runs one job per accepted start. It clears the array, then streams k_len
// operand columns from a 1-cycle-latency buffer into the array. It waits one
// cycle for the sums to settle, then steps res_sel 0..8 through a valid/ready
// handshake.
//
// Ports:
//   clk, clear_n            clock (rising edge), async active-low reset
//   start, k_len            job request (taken only in IDLE), inner dimension
//   busy, done              job in flight, one-cycle completion pulse
//   op_rd, op_addr          operand buffer read strobe / column address
//   op_w_data, op_x_data    {lane3,lane2,lane1} operand columns, 1 cycle after op_rd
//   data_w1..3, data_x1..3  operand lanes to the MAC array (0 when not loading)
//   mac_load, mac_clear     MAC accumulate enable / synchronous clear
//   res_sel, res_valid      row-major result index and its valid flag
//   res_ready               consumer accepts the current res_sel
module matmul_seq_ctrl #(
  parameter int unsigned KW = 4,
  parameter int unsigned DW = 4
) (
  input  logic            clk,
  input  logic            clear_n,
  input  logic            start,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            done,
  output logic            op_rd,
  output logic [KW-1:0]   op_addr,
  input  logic [3*DW-1:0] op_w_data,
  input  logic [3*DW-1:0] op_x_data,
  output logic [DW-1:0]   data_w1,
  output logic [DW-1:0]   data_w2,
  output logic [DW-1:0]   data_w3,
  output logic [DW-1:0]   data_x1,
  output logic [DW-1:0]   data_x2,
  output logic [DW-1:0]   data_x3,
  output logic            mac_load,
  output logic            mac_clear,
  output logic [3:0]      res_sel,
  output logic            res_valid,
  input  logic            res_ready
);

  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] LAST_SEL = SW'(8);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ACC, S_DRAIN, S_SETTLE, S_OUT, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] kreg_q, kreg_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          op_rd_q, op_rd_d;
  logic [KW-1:0] op_addr_q, op_addr_d;
  logic          mac_clear_q, mac_clear_d;
  logic [SW-1:0] res_sel_q, res_sel_d;
  logic          res_valid_q, res_valid_d;
  logic          mac_load_q;

  // State and registered outputs; mac_load is op_rd delayed to meet buffer latency.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      kreg_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_rd_q     <= 1'b0;
      op_addr_q   <= '0;
      mac_clear_q <= 1'b0;
      res_sel_q   <= '0;
      res_valid_q <= 1'b0;
      mac_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kreg_q      <= kreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_rd_q     <= op_rd_d;
      op_addr_q   <= op_addr_d;
      mac_clear_q <= mac_clear_d;
      res_sel_q   <= res_sel_d;
      res_valid_q <= res_valid_d;
      mac_load_q  <= op_rd_q;
    end
  end

  // Next state; outputs are decoded for the state being entered so they
  // appear registered in the cycle that state is occupied.
  always_comb begin
    state_d     = state_q;
    kreg_d      = kreg_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    op_rd_d     = 1'b0;
    op_addr_d   = '0;
    mac_clear_d = 1'b0;
    res_sel_d   = '0;
    res_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_CLR;
          kreg_d      = k_len;
          busy_d      = 1'b1;
          mac_clear_d = 1'b1;
        end
      end
      S_CLR: begin
        if (kreg_q == '0) begin
          state_d = S_SETTLE;
        end else begin
          state_d   = S_ACC;
          op_rd_d   = 1'b1;
          op_addr_d = '0;
        end
      end
      S_ACC: begin
        // The cycle issuing the last column address is the last ACC cycle.
        if (op_addr_q == kreg_q - KW'(1)) begin
          state_d = S_DRAIN;
        end else begin
          op_rd_d   = 1'b1;
          op_addr_d = op_addr_q + KW'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        state_d     = S_OUT;
        res_valid_d = 1'b1;
      end
      S_OUT: begin
        res_valid_d = 1'b1;
        res_sel_d   = res_sel_q;
        if (res_ready) begin
          if (res_sel_q == LAST_SEL) begin
            state_d     = S_FIN;
            res_valid_d = 1'b0;
            res_sel_d   = '0;
            done_d      = 1'b1;
          end else begin
            res_sel_d = res_sel_q + SW'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign op_rd     = op_rd_q;
  assign op_addr   = op_addr_q;
  assign mac_clear = mac_clear_q;
  assign mac_load  = mac_load_q;
  assign res_sel   = res_sel_q;
  assign res_valid = res_valid_q;

  // Operand lanes pass through only while loading so idle cycles present zero.
  assign data_w1 = mac_load_q ? op_w_data[DW-1:0]      : '0;
  assign data_w2 = mac_load_q ? op_w_data[2*DW-1:DW]   : '0;
  assign data_w3 = mac_load_q ? op_w_data[3*DW-1:2*DW] : '0;
  assign data_x1 = mac_load_q ? op_x_data[DW-1:0]      : '0;
  assign data_x2 = mac_load_q ? op_x_data[2*DW-1:DW]   : '0;
  assign data_x3 = mac_load_q ? op_x_data[3*DW-1:2*DW] : '0;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Self-checking bench for matmul_seq_ctrl with an operand-buffer model and a
// 3x3 MAC-array model fed from the DUT's lanes.
module tb_matmul_seq_ctrl;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        start;
  logic [3:0]  k_len;
  logic        busy, done, op_rd, mac_load, mac_clear, res_valid, res_ready;
  logic [3:0]  op_addr, res_sel;
  logic [11:0] op_w_data = '0;
  logic [11:0] op_x_data = '0;
  logic [3:0]  data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] w_mem [16];
  logic [11:0] x_mem [16];
  logic [7:0]  acc [9];
  logic [3:0]  wl [3];
  logic [3:0]  xl [3];

  typedef struct {
    int kl;
    int pat;
    int mode;     // 0 ready held high, 1 backpressure, 2 start pulses while busy + early restart
    int exp_lat;  // start cycle to done cycle, -1 = not checked
    int exp_res [9];
  } vec_t;

  vec_t vecs [6];

  matmul_seq_ctrl #(.KW(4), .DW(4)) dut (
    .clk(clk), .clear_n(clear_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .op_rd(op_rd), .op_addr(op_addr),
    .op_w_data(op_w_data), .op_x_data(op_x_data),
    .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
    .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
    .mac_load(mac_load), .mac_clear(mac_clear),
    .res_sel(res_sel), .res_valid(res_valid), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (op_rd) begin
      op_w_data <= w_mem[op_addr];
      op_x_data <= x_mem[op_addr];
    end
  end

  assign wl[0] = data_w1;
  assign wl[1] = data_w2;
  assign wl[2] = data_w3;
  assign xl[0] = data_x1;
  assign xl[1] = data_x2;
  assign xl[2] = data_x3;

  function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
    return {4'b0, a} * {4'b0, b};
  endfunction

  // MAC array: o(i,j) += w_i * x_j, 8-bit wrap, row-major index i*3+j.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (mac_clear) acc[i*3+j] <= 8'd0;
        else if (mac_load) acc[i*3+j] <= acc[i*3+j] + mul(wl[i], xl[j]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fill_mem(input int pat);
    logic [3:0] v;
    for (int c = 0; c < 16; c++) begin
      case (pat)
        0: begin
          v = (c == 1) ? 4'd2 : 4'd3;
          w_mem[c] = {v, v, v};
          x_mem[c] = {v, v, v};
        end
        1: begin
          w_mem[c] = {4'd15, 4'd15, 4'd15};
          x_mem[c] = {4'd15, 4'd15, 4'd15};
        end
        2: begin
          w_mem[c] = {4'd3, 4'd2, 4'd1};
          x_mem[c] = {4'd6, 4'd5, 4'd4};
        end
        default: begin
          w_mem[c] = {4'd5, 4'd5, 4'd5};
          x_mem[c] = {4'd7, 4'd7, 4'd7};
        end
      endcase
    end
  endtask

  task automatic run_job(input vec_t v);
    int   cyc, rd_cnt, ld_cnt, clr_cnt, hs_cnt, exp_sel, hold, done_cyc;
    logic tog;
    cyc = 0; rd_cnt = 0; ld_cnt = 0; clr_cnt = 0; hs_cnt = 0;
    exp_sel = 0; hold = 0; done_cyc = -1; tog = 1'b1;
    fill_mem(v.pat);
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    start = 1'b1;
    k_len = 4'(v.kl);
    res_ready = 1'b1;
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (v.mode == 2 && (cyc == 2 || (res_valid && res_sel == 4'd0))) begin
        start = 1'b1;
        k_len = 4'd9;
      end
      chk("busy_in_job", int'(busy), 1);
      chk("clr_ld_exclusive", int'(mac_clear & mac_load), 0);
      if (mac_clear) begin
        clr_cnt++;
        chk("clear_cycle", cyc, 1);
      end
      if (op_rd) begin
        chk("op_addr", int'(op_addr), rd_cnt);
        chk("rd_cycle", cyc, rd_cnt + 2);
        rd_cnt++;
      end
      if (mac_load) begin
        chk("ld_cycle", cyc, ld_cnt + 3);
        chk("data_w1", int'(data_w1), int'(w_mem[ld_cnt][3:0]));
        chk("data_x3", int'(data_x3), int'(x_mem[ld_cnt][11:8]));
        ld_cnt++;
      end else begin
        chk("data_idle_zero", int'({data_w1, data_w2, data_w3, data_x1, data_x2, data_x3}), 0);
      end
      if (res_valid) begin
        if (v.mode == 1) begin
          if (res_sel == 4'd4 && hold < 4) begin
            res_ready = 1'b0;
            hold++;
          end else if (hold >= 4) begin
            res_ready = tog;
            tog = ~tog;
          end else begin
            res_ready = 1'b1;
          end
        end else begin
          res_ready = 1'b1;
        end
        chk("res_sel_order", int'(res_sel), exp_sel);
        if (res_ready && exp_sel < 9) begin
          chk("result", int'(acc[exp_sel]), v.exp_res[exp_sel]);
          hs_cnt++;
          exp_sel++;
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk("fin_res_valid", int'(res_valid), 0);
        chk("fin_res_sel", int'(res_sel), 0);
      end
    end
    if (v.exp_lat >= 0) chk("done_latency", done_cyc, v.exp_lat);
    else chk("done_seen", int'(done_cyc > 0), 1);
    chk("read_count", rd_cnt, v.kl);
    chk("load_count", ld_cnt, v.kl);
    chk("clear_count", clr_cnt, 1);
    chk("handshake_count", hs_cnt, 9);
    if (v.mode == 2) start = 1'b1;
  endtask

  initial begin
    int done_cnt;
    clear_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    res_ready = 1'b0;
    for (int c = 0; c < 16; c++) begin
      w_mem[c] = '0;
      x_mem[c] = '0;
    end
    for (int i = 0; i < 9; i++) acc[i] = '0;

    vecs[0].kl = 3;  vecs[0].pat = 0; vecs[0].mode = 0; vecs[0].exp_lat = 16;
    vecs[0].exp_res = '{22, 22, 22, 22, 22, 22, 22, 22, 22};
    vecs[1].kl = 0;  vecs[1].pat = 0; vecs[1].mode = 0; vecs[1].exp_lat = 12;
    vecs[1].exp_res = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].kl = 2;  vecs[2].pat = 2; vecs[2].mode = 1; vecs[2].exp_lat = -1;
    vecs[2].exp_res = '{8, 10, 12, 16, 20, 24, 24, 30, 36};
    vecs[3].kl = 15; vecs[3].pat = 1; vecs[3].mode = 0; vecs[3].exp_lat = 28;
    vecs[3].exp_res = '{47, 47, 47, 47, 47, 47, 47, 47, 47};
    vecs[4].kl = 1;  vecs[4].pat = 3; vecs[4].mode = 2; vecs[4].exp_lat = 14;
    vecs[4].exp_res = '{35, 35, 35, 35, 35, 35, 35, 35, 35};
    vecs[5].kl = 4;  vecs[5].pat = 3; vecs[5].mode = 0; vecs[5].exp_lat = 17;
    vecs[5].exp_res = '{140, 140, 140, 140, 140, 140, 140, 140, 140};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_op_rd", int'(op_rd), 0);
    chk("rst_op_addr", int'(op_addr), 0);
    chk("rst_mac_load", int'(mac_load), 0);
    chk("rst_mac_clear", int'(mac_clear), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_sel", int'(res_sel), 0);
    clear_n = 1'b1;

    // Reset in the second ACC cycle abandons the job immediately.
    fill_mem(3);
    @(negedge clk);
    start = 1'b1;
    k_len = 4'd5;
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_load", int'(mac_load), 1);
    chk("pre_rst_op_rd", int'(op_rd), 1);
    clear_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_op_rd", int'(op_rd), 0);
    chk("arst_op_addr", int'(op_addr), 0);
    chk("arst_mac_load", int'(mac_load), 0);
    chk("arst_data", int'({data_w1, data_x1, data_w3, data_x3}), 0);
    chk("arst_mac_clear", int'(mac_clear), 0);
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    clear_n = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
      chk("post_rst_idle_busy", int'(busy), 0);
    end
    chk("post_rst_no_done", done_cnt, 0);

    for (int t = 0; t < 6; t++) run_job(vecs[t]);

    @(negedge clk);
    start = 1'b0;
    chk("final_idle_busy", int'(busy), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
